pixel_integrator: RTL and testbench

Parametrised multi-channel bitstream-to-colour reconstructor for the VGA capture path. Each channel takes a 1-bit comparator stream from GPIO, resynchronises it, and converts it to an intensity. Conversion is either a saturating up/down tracking integrator or a fixed-window ones counter. Each channel drives an OUT_W-bit colour output with blanking and per-channel masking, and the block sits between the GPIO comparator inputs and the VGA R/G/B registers.

---
 rtl/pixel_integrator_pkg.sv | 37 +++
 rtl/pixel_integrator_channel.sv | 81 ++++++++
 rtl/pixel_integrator.sv | 107 ++++++++++
 tb/tb_pixel_integrator.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_integrator_pkg.sv
`default_nettype none
// ============================================================================
// pixel_integrator_pkg : shared types and arithmetic helpers for pixel_integrator
// Revision : 1.0
// ============================================================================
package pixel_integrator_pkg;

    typedef enum logic {
        TRACK  = 1'b0,
        WINDOW = 1'b1
    } mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } win_state_e;

    // Wide intermediate arithmetic, so the clamp happens before any wrap could occur.
    function automatic int unsigned sat_add_sub(input int unsigned acc,
                                                input logic        dir_up,
                                                input int unsigned up_step,
                                                input int unsigned down_step,
                                                input int unsigned full_scale);
        if (dir_up) begin
            return (acc + up_step > full_scale) ? full_scale : acc + up_step;
        end
        return (down_step > acc) ? 32'd0 : acc - down_step;
    endfunction

    function automatic int unsigned replicate_scale(input int unsigned acc,
                                                    input int unsigned acc_w,
                                                    input int unsigned out_w);
        return (acc << (out_w - acc_w)) | (acc >> (2 * acc_w - out_w));
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_integrator_channel.sv
`default_nettype none
// ============================================================================
// pixel_integrator_channel : one comparator channel (sync, accumulate, scale)
// Revision : 1.0
// ============================================================================
module pixel_integrator_channel
    import pixel_integrator_pkg::*;
#(
    parameter int ACC_W       = 5,
    parameter int OUT_W       = 8,
    parameter int STEP_W      = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              bit_in,
    input  logic              visible,
    input  logic              mask,
    input  logic              clr_all,
    input  logic              track_en,
    input  logic              win_clr,
    input  logic              win_en,
    input  logic              win_last,
    input  logic [STEP_W-1:0] up_step,
    input  logic [STEP_W-1:0] down_step,
    output logic [ACC_W-1:0]  acc_out,
    output logic [OUT_W-1:0]  color_out
);

    localparam int unsigned FULL_SCALE = (1 << ACC_W) - 1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [ACC_W-1:0]       ones_q, ones_d;
    logic [OUT_W-1:0]       color_q, color_d;
    logic                   syn;

    assign syn = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], bit_in};
        acc_d  = acc_q;
        ones_d = ones_q;
        if (clr_all) begin
            acc_d  = '0;
            ones_d = '0;
        end else if (track_en) begin
            acc_d = ACC_W'(sat_add_sub(32'(acc_q), syn, 32'(up_step), 32'(down_step), FULL_SCALE));
        end else if (win_clr) begin
            ones_d = '0;
        end else if (win_en) begin
            // acc doubles as the latched window result in WINDOW mode
            if (win_last) begin
                acc_d  = ones_q + ACC_W'(syn);
                ones_d = '0;
            end else begin
                ones_d = ones_q + ACC_W'(syn);
            end
        end
        color_d = (visible && !mask) ? OUT_W'(replicate_scale(32'(acc_q), ACC_W, OUT_W)) : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q  <= '0;
            acc_q   <= '0;
            ones_q  <= '0;
            color_q <= '0;
        end else begin
            sync_q  <= sync_d;
            acc_q   <= acc_d;
            ones_q  <= ones_d;
            color_q <= color_d;
        end
    end

    assign acc_out   = acc_q;
    assign color_out = color_q;

endmodule
`default_nettype wire

// File: rtl/pixel_integrator.sv
`default_nettype none
// ============================================================================
// pixel_integrator : multi-channel comparator bitstream to colour reconstructor
// Revision : 1.0
// ============================================================================
module pixel_integrator
    import pixel_integrator_pkg::*;
#(
    parameter int CHANNELS    = 3,
    parameter int ACC_W       = 5,
    parameter int OUT_W       = 8,
    parameter int STEP_W      = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       bits_in,
    input  logic                      visible,
    input  logic                      mode,
    input  logic [STEP_W-1:0]         up_step,
    input  logic [STEP_W-1:0]         down_step,
    input  logic [CHANNELS-1:0]       chan_mask,
    output logic [CHANNELS*ACC_W-1:0] acc_out,
    output logic [CHANNELS*OUT_W-1:0] color_out,
    output logic                      color_valid
);

    localparam logic [ACC_W-1:0] WIN_LAST = ACC_W'((1 << ACC_W) - 2);

    mode_e            mode_q;
    win_state_e       state_q;
    logic [ACC_W-1:0] win_cnt_q;
    logic             visible_q;

    logic mode_chg, track_en, win_clr, win_en, win_last;

    // The cycle the mode changes only clears; the new mode acts from the next cycle.
    assign mode_chg = (mode_e'(mode) != mode_q);
    assign track_en = !mode_chg && (mode_q == TRACK) && visible;
    assign win_clr  = !mode_chg && (mode_q == WINDOW) && (state_q == IDLE) && visible;
    assign win_en   = !mode_chg && (mode_q == WINDOW) && (state_q == COUNT) && visible;
    assign win_last = (win_cnt_q == WIN_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            mode_q    <= mode_e'(mode);
            state_q   <= IDLE;
            win_cnt_q <= '0;
            visible_q <= 1'b0;
        end else begin
            mode_q    <= mode_e'(mode);
            visible_q <= visible;
            if (mode_chg || mode_q != WINDOW) begin
                state_q   <= IDLE;
                win_cnt_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (visible) begin
                            state_q   <= COUNT;
                            win_cnt_q <= '0;
                        end
                    end
                    COUNT: begin
                        if (!visible) begin
                            state_q   <= IDLE;
                            win_cnt_q <= '0;
                        end else if (win_last) begin
                            win_cnt_q <= '0;
                        end else begin
                            win_cnt_q <= win_cnt_q + ACC_W'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign color_valid = visible_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        pixel_integrator_channel #(
            .ACC_W       (ACC_W),
            .OUT_W       (OUT_W),
            .STEP_W      (STEP_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clock     (clock),
            .reset     (reset),
            .bit_in    (bits_in[c]),
            .visible   (visible),
            .mask      (chan_mask[c]),
            .clr_all   (mode_chg),
            .track_en  (track_en),
            .win_clr   (win_clr),
            .win_en    (win_en),
            .win_last  (win_last),
            .up_step   (up_step),
            .down_step (down_step),
            .acc_out   (acc_out[c*ACC_W +: ACC_W]),
            .color_out (color_out[c*OUT_W +: OUT_W])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_pixel_integrator.sv
`default_nettype none
// ============================================================================
// tb_pixel_integrator : randomized bench against a cycle-level behavioural model
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_pixel_integrator;

    localparam int CH = 3, AW = 5, OW = 8, SW = 3, SS = 2;
    localparam int FULL = (1 << AW) - 1;
    localparam int WIN  = FULL;

    logic             clock = 1'b0;
    logic             reset, visible, mode;
    logic [CH-1:0]    bits_in, chan_mask;
    logic [SW-1:0]    up_step, down_step;
    logic [CH*AW-1:0] acc_out;
    logic [CH*OW-1:0] color_out;
    logic             color_valid;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    pixel_integrator #(
        .CHANNELS(CH), .ACC_W(AW), .OUT_W(OW), .STEP_W(SW), .SYNC_STAGES(SS)
    ) dut (
        .clock(clock), .reset(reset), .bits_in(bits_in), .visible(visible), .mode(mode),
        .up_step(up_step), .down_step(down_step), .chan_mask(chan_mask),
        .acc_out(acc_out), .color_out(color_out), .color_valid(color_valid)
    );

    // Reference model: synchroniser as a queue of past inputs, window as a cycle count.
    logic [CH-1:0]    m_hist[$];
    int               m_acc[CH], m_ones[CH], m_col[CH];
    bit               m_mode, m_valid, m_inwin;
    int               m_phase;
    logic [CH*AW-1:0] exp_acc;
    logic [CH*OW-1:0] exp_col;

    function automatic int scale(input int a);
        logic [AW-1:0] v;
        v = AW'(a);
        return int'({v, v[AW-1 -: OW-AW]});
    endfunction

    task automatic model_step();
        logic [CH-1:0] syn;
        int t;
        if (reset) begin
            m_hist.delete();
            repeat (SS) m_hist.push_front('0);
            for (int c = 0; c < CH; c++) begin
                m_acc[c] = 0; m_ones[c] = 0; m_col[c] = 0;
            end
            m_mode = mode; m_valid = 0; m_inwin = 0; m_phase = 0;
        end else begin
            syn = m_hist[$];
            for (int c = 0; c < CH; c++)
                m_col[c] = (visible && !chan_mask[c]) ? scale(m_acc[c]) : 0;
            m_valid = visible;
            if (mode != m_mode) begin
                for (int c = 0; c < CH; c++) begin m_acc[c] = 0; m_ones[c] = 0; end
                m_mode = mode; m_inwin = 0;
            end else if (!m_mode) begin
                if (visible) begin
                    for (int c = 0; c < CH; c++) begin
                        if (syn[c]) t = m_acc[c] + int'(up_step);
                        else        t = m_acc[c] - int'(down_step);
                        m_acc[c] = (t > FULL) ? FULL : (t < 0) ? 0 : t;
                    end
                end
            end else if (!visible) begin
                m_inwin = 0;
            end else if (!m_inwin) begin
                m_inwin = 1; m_phase = 0;
                for (int c = 0; c < CH; c++) m_ones[c] = 0;
            end else begin
                m_phase++;
                for (int c = 0; c < CH; c++) m_ones[c] += int'(syn[c]);
                if (m_phase == WIN) begin
                    for (int c = 0; c < CH; c++) begin m_acc[c] = m_ones[c]; m_ones[c] = 0; end
                    m_phase = 0;
                end
            end
            m_hist.push_front(bits_in);
            void'(m_hist.pop_back());
        end
        for (int c = 0; c < CH; c++) begin
            exp_acc[c*AW +: AW] = AW'(m_acc[c]);
            exp_col[c*OW +: OW] = OW'(m_col[c]);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++;
        if (acc_out !== '0 || color_out !== '0 || color_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset: acc=%h color=%h valid=%b, required all 0", acc_out, color_out, color_valid);
        end
        reset = 1'b0;
    endtask

    task automatic test_track_saturation();
        mode = 1'b0; up_step = 3'd3; down_step = 3'd0; bits_in = '1; visible = 1'b1;
        for (int i = 0; i < 24; i++) begin
            tick();
            checks++;
            if (acc_out !== exp_acc || color_out !== exp_col) begin
                errors++;
                $display("FAIL track_sat cyc %0d: acc=%h col=%h, required acc=%h col=%h", i, acc_out, color_out, exp_acc, exp_col);
            end
        end
        checks++;
        if (acc_out !== {CH{5'd31}} || color_out !== {CH{8'd255}}) begin
            errors++;
            $display("FAIL track_sat_final: acc=%h col=%h, required 7fff / ffffff", acc_out, color_out);
        end
    endtask

    task automatic test_track_floor();
        up_step = 3'd0; down_step = 3'd4; bits_in = '0;
        for (int i = 0; i < 14; i++) begin
            tick();
            checks++;
            if (acc_out !== exp_acc) begin
                errors++;
                $display("FAIL track_floor cyc %0d: acc=%h, required %h", i, acc_out, exp_acc);
            end
        end
        checks++;
        if (acc_out !== '0 || color_out !== '0) begin
            errors++;
            $display("FAIL track_floor_final: acc=%h col=%h, required 0", acc_out, color_out);
        end
    endtask

    task automatic test_window_count();
        mode = 1'b1; visible = 1'b0;
        repeat (3) tick();
        checks++;
        if (acc_out !== '0) begin
            errors++;
            $display("FAIL window_enter: acc=%h, required 0", acc_out);
        end
        bits_in = {CH-1{1'b0}} | {$urandom_range(3), 1'b1};
        tick();
        visible = 1'b1; bits_in[0] = 1'b0;
        tick();
        for (int i = 0; i < WIN; i++) begin
            bits_in = {2'($urandom), (i % 2 == 0)};
            tick();
            checks++;
            if (acc_out !== exp_acc) begin
                errors++;
                $display("FAIL window cyc %0d: acc=%h, required %h", i, acc_out, exp_acc);
            end
        end
        checks++;
        if (acc_out[AW-1:0] !== 5'd16) begin
            errors++;
            $display("FAIL window_ch0: acc=%0d, required 16", acc_out[AW-1:0]);
        end
        tick();
        checks++;
        if (color_out[OW-1:0] !== 8'd132) begin
            errors++;
            $display("FAIL window_color_ch0: color=%0d, required 132", color_out[OW-1:0]);
        end
    endtask

    task automatic test_blank_mask();
        logic prev_vis;
        mode = 1'b0; chan_mask = 3'b010;
        for (int i = 0; i < 40; i++) begin
            bits_in = CH'($urandom); visible = ($urandom_range(3) != 0);
            up_step = SW'($urandom); down_step = SW'($urandom);
            prev_vis = visible;
            tick();
            checks++;
            if (color_out[OW +: OW] !== '0 || color_valid !== prev_vis || acc_out !== exp_acc || color_out !== exp_col) begin
                errors++;
                $display("FAIL blank_mask cyc %0d: acc=%h col=%h valid=%b, required acc=%h col=%h valid=%b",
                         i, acc_out, color_out, color_valid, exp_acc, exp_col, prev_vis);
            end
        end
        chan_mask = '0;
    endtask

    task automatic test_abort();
        logic [CH*AW-1:0] saved;
        mode = 1'b1; visible = 1'b0; bits_in = '1;
        repeat (2) tick();
        visible = 1'b1;
        for (int i = 0; i < WIN + 1; i++) begin
            bits_in = CH'($urandom) | 3'b001;
            tick();
        end
        saved = exp_acc;
        for (int i = 0; i < 11; i++) begin
            bits_in = CH'($urandom);
            tick();
        end
        visible = 1'b0;
        repeat (3) begin
            tick();
            checks++;
            if (acc_out !== saved) begin
                errors++;
                $display("FAIL abort_hold: acc=%h, required %h", acc_out, saved);
            end
        end
        visible = 1'b1;
        for (int i = 0; i < WIN + 2; i++) begin
            bits_in = CH'($urandom);
            tick();
            checks++;
            if (acc_out !== exp_acc) begin
                errors++;
                $display("FAIL abort_restart cyc %0d: acc=%h, required %h", i, acc_out, exp_acc);
            end
        end
    endtask

    task automatic test_mode_toggle();
        mode = 1'b0; up_step = 3'd7; bits_in = '1; visible = 1'b1;
        repeat (8) tick();
        mode = 1'b1;
        tick();
        checks++;
        if (acc_out !== '0) begin
            errors++;
            $display("FAIL mode_toggle: acc=%h, required 0", acc_out);
        end
    endtask

    task automatic test_reset_mid();
        mode = 1'b0; up_step = 3'd5; down_step = 3'd0; bits_in = '1; visible = 1'b1;
        repeat (6) tick();
        reset = 1'b1; mode = 1'b1;
        tick();
        checks++;
        if (acc_out !== '0 || color_out !== '0 || color_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: acc=%h col=%h valid=%b, required all 0", acc_out, color_out, color_valid);
        end
        mode = 1'b0;
        tick();
        reset = 1'b0; bits_in = '0;
        repeat (4) tick();
        bits_in[0] = 1'b1;
        for (int k = 1; k <= SS + 2; k++) begin
            tick();
            checks++;
            if (color_out[OW-1:0] !== ((k == SS + 2) ? 8'd41 : 8'd0) || color_out !== exp_col) begin
                errors++;
                $display("FAIL latency k=%0d: color=%0d, required %0d", k, color_out[OW-1:0], (k == SS + 2) ? 41 : 0);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bits_in = CH'($urandom); visible = ($urandom_range(9) != 0);
            up_step = SW'($urandom); down_step = SW'($urandom);
            chan_mask = ($urandom_range(7) == 0) ? CH'($urandom) : '0;
            if ($urandom_range(99) < 2) mode = ~mode;
            tick();
            checks++;
            if (acc_out !== exp_acc || color_out !== exp_col || color_valid !== m_valid) begin
                errors++;
                $display("FAIL random cyc %0d: acc=%h col=%h valid=%b, required acc=%h col=%h valid=%b",
                         i, acc_out, color_out, color_valid, exp_acc, exp_col, m_valid);
            end
        end
    endtask

    initial begin
        reset = 1'b1; visible = 1'b0; mode = 1'b0; bits_in = '0;
        chan_mask = '0; up_step = '0; down_step = '0;
        test_reset();
        test_track_saturation();
        test_track_floor();
        test_window_count();
        test_blank_mask();
        test_abort();
        test_mode_toggle();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
